char_motion_ctrl: RTL and testbench
===================================

# char_motion_ctrl

Per-frame character motion and screen sequencer for the platformer. Once per frame it samples the player keys and the collision flags of the currently active screen, then computes X/Y motion: walk, jump, gravity and ceiling/floor stops. It updates the character position and advances or retreats the screen index when the character leaves the top or bottom of the play field. It sits between the keyboard decoder, the per-screen collision detectors (whose flags it selects by `screen_idx`) and the sprite/VGA drawing logic.

## Interface

Parameters:
- `NUM_SCREENS`, default 4: number of screens; `screen_idx` saturates at `NUM_SCREENS-1`.
- `X_START`, default 320: reset X position.
- `Y_START`, default 380: reset Y position.
- `STEP_X`, default 2: horizontal speed in px/frame.
- `JUMP_V`, default 8: initial upward speed, applied as Y_Motion = −JUMP_V.
- `MAX_FALL`, default 6: maximum downward Y_Motion.
- `GRAV_DIV`, default 2: Y_Motion increases by 1 every GRAV_DIV airborne frames.
- `Y_ENTRY_BOTTOM`, default 440: Y position after moving up a screen.
- `Y_ENTRY_TOP`, default 40: Y position after moving down a screen.

Ports:
- `Clk`  in  1  system clock.
- `Reset_n`  in  1  reset: asynchronous, active-low.
- `frame_tick`  in  1  one-cycle pulse per video frame.
- `key_left`, `key_right`, `key_jump`  in  1 each  level-sensitive key states.
- `top_collide_v`, `bottom_collide_v`, `left_collide_v`, `right_collide_v`  in  NUM_SCREENS each  per-screen collision flags; bit i belongs to screen i.
- `ts_collide`, `bs_collide`  in  1 each  play-field top and bottom edge flags.
- `Char_X_Pos`, `Char_Y_Pos`  out  10 each  character centre position.
- `Char_X_Motion`, `Char_Y_Motion`  out  10 each  two's-complement motion.
- `screen_idx`  out  $clog2(NUM_SCREENS)  active screen.
- `airborne`  out  1  high while not grounded.
- `screen_change`  out  1  one-cycle pulse on every screen transition.

## Operation

- States:
  - IDLE→SAMPLE on `frame_tick`.
  - SAMPLE→UPDATE unconditionally.
  - UPDATE→XFER if a transition condition holds, else UPDATE→MOVE.
  - MOVE→IDLE.
  - XFER→IDLE.
- SAMPLE: register the four flags at bit `screen_idx`, plus `ts_collide`, `bs_collide` and the three keys.
- UPDATE, horizontal motion:
  - right && !left && !right_flag → +STEP_X.
  - left && !right && !left_flag → −STEP_X.
  - Any other combination → 0.
- UPDATE, vertical motion (first matching rule wins):
  1. bottom_flag && Y_Motion≥0 (grounded): if jump, Y_Motion=−JUMP_V, airborne=1, grav_cnt=0; else Y_Motion=0, airborne=0.
  2. top_flag && Y_Motion<0: Y_Motion=0 (ceiling bump), airborne=1.
  3. Otherwise: airborne=1. grav_cnt increments; on reaching GRAV_DIV−1 it wraps to 0 and Y_Motion is incremented, saturating at +MAX_FALL.
- Transition conditions, evaluated in UPDATE on the sampled flags; up has priority:
  - Up: ts && Y_Motion<0 && screen_idx<NUM_SCREENS−1.
  - Down: bs && !bottom_flag && screen_idx>0.
- XFER:
  - Change screen_idx by ±1.
  - Set Y_Pos to Y_ENTRY_BOTTOM (up) or Y_ENTRY_TOP (down); X_Pos unchanged.
  - Keep Y_Motion; clear X_Motion; pulse `screen_change`. No MOVE happens that frame.
- ts on the last screen, or bs on screen 0, gives no transition; the normal collision rules apply.
- MOVE: Pos ← Pos + Motion, 10-bit modulo (wraps, no clamp). Keeping the character in bounds is the job of the collision flags.
- `frame_tick` is ignored outside IDLE.

## Timing

- Reset values:
  - X=X_START, Y=Y_START.
  - Both motions 0.
  - screen_idx=0, airborne=0, screen_change=0, grav_cnt=0.
  - State IDLE.
- With tick at cycle t: flags sampled at t+1, motion registered at t+2, position (or XFER result) registered at t+3.
- Collision inputs must be stable at t+1. They derive combinationally from the position registers, which settle at least one frame earlier.
- Reset asserted mid-sequence returns all outputs to their reset values immediately. The first tick after deassertion starts a fresh sequence.
- Motion outputs hold between frames.

## Structure

- Package `char_ctrl_pkg`:
  - State enum `ctrl_state_t` (IDLE, SAMPLE, UPDATE, MOVE, XFER).
  - 10-bit `coord_t`.
  - Default constants for play-field geometry.
- Sub-module `collide_sel`: a NUM_SCREENS-to-1 mux of the four flag vectors by `screen_idx`.
- FSM, motion arithmetic and position registers stay in the top module.

## Test plan

- Reset and idle: release Reset_n with no tick → outputs X=320, Y=380, screen 0, motions 0; ten idle cycles leave them unchanged.
- Walk: key_right held, no flags, 5 ticks → X=330. Assert right_collide_v[0] → next frame X_Motion=0 and X holds.
- Jump: bottom flag set, key_jump for one frame → Y_Motion=−8, Y=372, airborne=1. Subsequent frames Y_Motion follows −8,−8,−7,−7,… (GRAV_DIV=2), capped at +6.
- Ceiling: rising with Y_Motion=−5, assert top flag → Y_Motion=0 that frame, then gravity resumes.
- Screen up, then down:
  - Rising with ts=1 on screen 0 → screen 1, Y=440, screen_change pulses once.
  - bs=1 with no bottom flag on screen 1 → screen 0, Y=40.
  - ts on screen 3 → no change.
- Robustness:
  - A second tick during SAMPLE is ignored: exactly one update per sequence.
  - Reset_n low during UPDATE → immediate reset values.

Source files
------------

// File: rtl/char_ctrl_pkg.sv
// Shared types and default geometry for the character motion controller.
//   ctrl_state_t : per-frame sequencer states
//   coord_t      : 10-bit screen coordinate / motion word
//   sample_t     : flags and keys captured once per frame
//   idx_w()      : index width helper that never returns zero
package char_ctrl_pkg;

  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    UPDATE,
    MOVE,
    XFER
  } ctrl_state_t;

  typedef struct packed {
    logic top;
    logic bottom;
    logic left;
    logic right;
    logic ts;
    logic bs;
    logic key_left;
    logic key_right;
    logic key_jump;
  } sample_t;

  // Default play-field geometry and motion tuning.
  localparam int DEF_NUM_SCREENS    = 4;
  localparam int DEF_X_START        = 320;
  localparam int DEF_Y_START        = 380;
  localparam int DEF_STEP_X         = 2;
  localparam int DEF_JUMP_V         = 8;
  localparam int DEF_MAX_FALL       = 6;
  localparam int DEF_GRAV_DIV       = 2;
  localparam int DEF_Y_ENTRY_BOTTOM = 440;
  localparam int DEF_Y_ENTRY_TOP    = 40;

  // Width of an index over n items; a single item still gets one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/char_motion_ctrl_collide_sel.sv
// collide_sel: picks the four collision flags belonging to the active screen.
//   sel                 : active screen index
//   top_v/bottom_v/...  : per-screen flag vectors, bit i = screen i
//   top_flag/...        : flags of the selected screen (0 if sel is out of range)
module collide_sel
  import char_ctrl_pkg::*;
#(
  parameter int NUM_SCREENS = DEF_NUM_SCREENS
) (
  input  logic [idx_w(NUM_SCREENS)-1:0] sel,
  input  logic [NUM_SCREENS-1:0]        top_v,
  input  logic [NUM_SCREENS-1:0]        bottom_v,
  input  logic [NUM_SCREENS-1:0]        left_v,
  input  logic [NUM_SCREENS-1:0]        right_v,
  output logic                          top_flag,
  output logic                          bottom_flag,
  output logic                          left_flag,
  output logic                          right_flag
);

  localparam int IDX_W = idx_w(NUM_SCREENS);

  // Compare-per-screen form keeps the mux safe for non-power-of-two counts.
  always_comb begin
    top_flag    = 1'b0;
    bottom_flag = 1'b0;
    left_flag   = 1'b0;
    right_flag  = 1'b0;
    for (int i = 0; i < NUM_SCREENS; i++) begin
      if (sel == IDX_W'(i)) begin
        top_flag    = top_v[i];
        bottom_flag = bottom_v[i];
        left_flag   = left_v[i];
        right_flag  = right_v[i];
      end
    end
  end

endmodule

// File: rtl/char_motion_ctrl.sv
// char_motion_ctrl: per-frame character motion and screen sequencer.
// Each frame_tick runs IDLE -> SAMPLE -> UPDATE -> (MOVE | XFER) -> IDLE.
//   Clk, Reset_n                : clock, asynchronous active-low reset
//   frame_tick                  : one-cycle pulse per video frame
//   key_left/right/jump         : level key states
//   *_collide_v                 : per-screen collision flags, bit i = screen i
//   ts_collide, bs_collide      : play-field top / bottom edge flags
//   Char_X_Pos, Char_Y_Pos      : character centre position
//   Char_X_Motion, Char_Y_Motion: two's-complement motion per frame
//   screen_idx                  : active screen
//   airborne                    : high while not grounded
//   screen_change               : one-cycle pulse on each screen transition
module char_motion_ctrl
  import char_ctrl_pkg::*;
#(
  parameter int NUM_SCREENS    = DEF_NUM_SCREENS,
  parameter int X_START        = DEF_X_START,
  parameter int Y_START        = DEF_Y_START,
  parameter int STEP_X         = DEF_STEP_X,
  parameter int JUMP_V         = DEF_JUMP_V,
  parameter int MAX_FALL       = DEF_MAX_FALL,
  parameter int GRAV_DIV       = DEF_GRAV_DIV,
  parameter int Y_ENTRY_BOTTOM = DEF_Y_ENTRY_BOTTOM,
  parameter int Y_ENTRY_TOP    = DEF_Y_ENTRY_TOP
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          frame_tick,
  input  logic                          key_left,
  input  logic                          key_right,
  input  logic                          key_jump,
  input  logic [NUM_SCREENS-1:0]        top_collide_v,
  input  logic [NUM_SCREENS-1:0]        bottom_collide_v,
  input  logic [NUM_SCREENS-1:0]        left_collide_v,
  input  logic [NUM_SCREENS-1:0]        right_collide_v,
  input  logic                          ts_collide,
  input  logic                          bs_collide,
  output logic [COORD_W-1:0]            Char_X_Pos,
  output logic [COORD_W-1:0]            Char_Y_Pos,
  output logic [COORD_W-1:0]            Char_X_Motion,
  output logic [COORD_W-1:0]            Char_Y_Motion,
  output logic [idx_w(NUM_SCREENS)-1:0] screen_idx,
  output logic                          airborne,
  output logic                          screen_change
);

  localparam int IDX_W = idx_w(NUM_SCREENS);
  localparam int GC_W  = idx_w(GRAV_DIV);

  localparam logic [IDX_W-1:0]          LAST_IDX = IDX_W'(NUM_SCREENS - 1);
  localparam logic [GC_W-1:0]           GC_LAST  = GC_W'(GRAV_DIV - 1);
  localparam coord_t                    X_RST    = coord_t'(X_START);
  localparam coord_t                    Y_RST    = coord_t'(Y_START);
  localparam coord_t                    Y_ENT_B  = coord_t'(Y_ENTRY_BOTTOM);
  localparam coord_t                    Y_ENT_T  = coord_t'(Y_ENTRY_TOP);
  localparam logic signed [COORD_W-1:0] STEP_C   = COORD_W'(STEP_X);
  localparam logic signed [COORD_W-1:0] JUMP_C   = COORD_W'(JUMP_V);
  localparam logic signed [COORD_W-1:0] FALL_C   = COORD_W'(MAX_FALL);
  localparam logic signed [COORD_W-1:0] ONE_C    = COORD_W'(1);

  ctrl_state_t               state_q, state_d;
  sample_t                   smp_q, smp_d;
  coord_t                    x_pos_q, x_pos_d;
  coord_t                    y_pos_q, y_pos_d;
  logic signed [COORD_W-1:0] x_mot_q, x_mot_d;
  logic signed [COORD_W-1:0] y_mot_q, y_mot_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [GC_W-1:0]           gc_q, gc_d;
  logic                      air_q, air_d;
  logic                      chg_q, chg_d;
  logic                      up_q, up_d;

  logic sel_top, sel_bottom, sel_left, sel_right;
  logic go_up, go_down;

  // Gravity step toward the terminal fall speed.
  function automatic logic signed [COORD_W-1:0] sat_fall_inc(
    input logic signed [COORD_W-1:0] v
  );
    if (v >= FALL_C) return FALL_C;
    return v + ONE_C;
  endfunction

  collide_sel #(
    .NUM_SCREENS(NUM_SCREENS)
  ) u_collide_sel (
    .sel         (idx_q),
    .top_v       (top_collide_v),
    .bottom_v    (bottom_collide_v),
    .left_v      (left_collide_v),
    .right_v     (right_collide_v),
    .top_flag    (sel_top),
    .bottom_flag (sel_bottom),
    .left_flag   (sel_left),
    .right_flag  (sel_right)
  );

  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    x_pos_d = x_pos_q;
    y_pos_d = y_pos_q;
    x_mot_d = x_mot_q;
    y_mot_d = y_mot_q;
    idx_d   = idx_q;
    gc_d    = gc_q;
    air_d   = air_q;
    chg_d   = 1'b0;
    up_d    = up_q;
    go_up   = 1'b0;
    go_down = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_tick) state_d = SAMPLE;
      end

      SAMPLE: begin
        smp_d.top       = sel_top;
        smp_d.bottom    = sel_bottom;
        smp_d.left      = sel_left;
        smp_d.right     = sel_right;
        smp_d.ts        = ts_collide;
        smp_d.bs        = bs_collide;
        smp_d.key_left  = key_left;
        smp_d.key_right = key_right;
        smp_d.key_jump  = key_jump;
        state_d         = UPDATE;
      end

      UPDATE: begin
        if (smp_q.key_right && !smp_q.key_left && !smp_q.right)
          x_mot_d = STEP_C;
        else if (smp_q.key_left && !smp_q.key_right && !smp_q.left)
          x_mot_d = -STEP_C;
        else
          x_mot_d = '0;

        // Grounded needs a non-negative motion so a rising jump passes
        // through floor flags instead of snapping down onto them.
        if (smp_q.bottom && !y_mot_q[COORD_W-1]) begin
          if (smp_q.key_jump) begin
            y_mot_d = -JUMP_C;
            air_d   = 1'b1;
            gc_d    = '0;
          end else begin
            y_mot_d = '0;
            air_d   = 1'b0;
          end
        end else if (smp_q.top && y_mot_q[COORD_W-1]) begin
          y_mot_d = '0;
          air_d   = 1'b1;
        end else begin
          air_d = 1'b1;
          if (gc_q == GC_LAST) begin
            gc_d    = '0;
            y_mot_d = sat_fall_inc(y_mot_q);
          end else begin
            gc_d = gc_q + 1'b1;
          end
        end

        // Upward exit uses this frame's freshly computed motion.
        go_up   = smp_q.ts && y_mot_d[COORD_W-1] && (idx_q < LAST_IDX);
        go_down = smp_q.bs && !smp_q.bottom && (idx_q != '0);
        up_d    = go_up;
        state_d = (go_up || go_down) ? XFER : MOVE;
      end

      MOVE: begin
        x_pos_d = x_pos_q + coord_t'(x_mot_q);
        y_pos_d = y_pos_q + coord_t'(y_mot_q);
        state_d = IDLE;
      end

      XFER: begin
        if (up_q) begin
          idx_d   = idx_q + 1'b1;
          y_pos_d = Y_ENT_B;
        end else begin
          idx_d   = idx_q - 1'b1;
          y_pos_d = Y_ENT_T;
        end
        x_mot_d = '0;
        chg_d   = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      smp_q   <= '0;
      x_pos_q <= X_RST;
      y_pos_q <= Y_RST;
      x_mot_q <= '0;
      y_mot_q <= '0;
      idx_q   <= '0;
      gc_q    <= '0;
      air_q   <= 1'b0;
      chg_q   <= 1'b0;
      up_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      x_pos_q <= x_pos_d;
      y_pos_q <= y_pos_d;
      x_mot_q <= x_mot_d;
      y_mot_q <= y_mot_d;
      idx_q   <= idx_d;
      gc_q    <= gc_d;
      air_q   <= air_d;
      chg_q   <= chg_d;
      up_q    <= up_d;
    end
  end

  assign Char_X_Pos    = x_pos_q;
  assign Char_Y_Pos    = y_pos_q;
  assign Char_X_Motion = x_mot_q;
  assign Char_Y_Motion = y_mot_q;
  assign screen_idx    = idx_q;
  assign airborne      = air_q;
  assign screen_change = chg_q;

endmodule

// File: tb/tb_char_motion_ctrl.sv
// Testbench for char_motion_ctrl: directed scenarios plus randomized frames,
// every cycle compared against a frame-level behavioural model.
module tb_char_motion_ctrl;

  logic       Clk;
  logic       Reset_n;
  logic       frame_tick;
  logic       key_left, key_right, key_jump;
  logic [3:0] top_collide_v, bottom_collide_v, left_collide_v, right_collide_v;
  logic       ts_collide, bs_collide;
  logic [9:0] Char_X_Pos, Char_Y_Pos, Char_X_Motion, Char_Y_Motion;
  logic [1:0] screen_idx;
  logic       airborne, screen_change;

  int n_cmp = 0;
  int n_bad = 0;

  char_motion_ctrl dut (
    .Clk              (Clk),
    .Reset_n          (Reset_n),
    .frame_tick       (frame_tick),
    .key_left         (key_left),
    .key_right        (key_right),
    .key_jump         (key_jump),
    .top_collide_v    (top_collide_v),
    .bottom_collide_v (bottom_collide_v),
    .left_collide_v   (left_collide_v),
    .right_collide_v  (right_collide_v),
    .ts_collide       (ts_collide),
    .bs_collide       (bs_collide),
    .Char_X_Pos       (Char_X_Pos),
    .Char_Y_Pos       (Char_Y_Pos),
    .Char_X_Motion    (Char_X_Motion),
    .Char_Y_Motion    (Char_Y_Motion),
    .screen_idx       (screen_idx),
    .airborne         (airborne),
    .screen_change    (screen_change)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- behavioural model (frame level) ----------------
  int m_x = 320, m_y = 380, m_xm = 0, m_ym = 0, m_idx = 0;
  int m_air = 0, m_chg = 0, m_gc = 0;
  int m_busy = 0;           // cycles since an accepted tick, 0 = ready
  bit s_t, s_b, s_l, s_r, s_ts, s_bs, s_kl, s_kr, s_kj;
  bit p_up, p_dn;

  initial forever begin
    @(posedge Clk or negedge Reset_n);
    if (!Reset_n) begin
      m_x = 320; m_y = 380; m_xm = 0; m_ym = 0; m_idx = 0;
      m_air = 0; m_chg = 0; m_gc = 0; m_busy = 0; p_up = 0; p_dn = 0;
    end else begin
      m_chg = 0;
      if (m_busy == 0) begin
        if (frame_tick) m_busy = 1;
      end else if (m_busy == 1) begin
        s_t  = top_collide_v[m_idx];
        s_b  = bottom_collide_v[m_idx];
        s_l  = left_collide_v[m_idx];
        s_r  = right_collide_v[m_idx];
        s_ts = ts_collide; s_bs = bs_collide;
        s_kl = key_left; s_kr = key_right; s_kj = key_jump;
        m_busy = 2;
      end else if (m_busy == 2) begin
        if (s_kr && !s_kl && !s_r)      m_xm = 2;
        else if (s_kl && !s_kr && !s_l) m_xm = -2;
        else                            m_xm = 0;
        if (s_b && m_ym >= 0) begin
          if (s_kj) begin m_ym = -8; m_air = 1; m_gc = 0; end
          else begin m_ym = 0; m_air = 0; end
        end else if (s_t && m_ym < 0) begin
          m_ym = 0; m_air = 1;
        end else begin
          m_air = 1;
          m_gc  = m_gc + 1;
          if (m_gc == 2) begin
            m_gc = 0;
            if (m_ym < 6) m_ym = m_ym + 1;
          end
        end
        p_up = s_ts && (m_ym < 0) && (m_idx < 3);
        p_dn = s_bs && !s_b && (m_idx > 0);
        m_busy = 3;
      end else begin
        if (p_up) begin
          m_idx = m_idx + 1; m_y = 440; m_xm = 0; m_chg = 1;
        end else if (p_dn) begin
          m_idx = m_idx - 1; m_y = 40; m_xm = 0; m_chg = 1;
        end else begin
          m_x = (m_x + m_xm) & 1023;
          m_y = (m_y + m_ym) & 1023;
        end
        m_busy = 0;
      end
    end
  end

  // ---------------- checking ----------------
  function automatic logic [9:0] t10(input int v);
    return 10'(v);
  endfunction

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic cmp_all();
    chk("x_pos",    Char_X_Pos,           t10(m_x));
    chk("y_pos",    Char_Y_Pos,           t10(m_y));
    chk("x_motion", Char_X_Motion,        t10(m_xm));
    chk("y_motion", Char_Y_Motion,        t10(m_ym));
    chk("screen",   {8'd0, screen_idx},   t10(m_idx));
    chk("airborne", {9'd0, airborne},     t10(m_air));
    chk("scr_chg",  {9'd0, screen_change}, t10(m_chg));
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      cmp_all();
    end
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    cyc(5);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  int jump_seq [4] = '{-8, -7, -7, -6};
  int ticklen, gap;

  initial begin
    Reset_n = 1'b0; frame_tick = 1'b0;
    key_left = 1'b0; key_right = 1'b0; key_jump = 1'b0;
    top_collide_v = '0; bottom_collide_v = '0;
    left_collide_v = '0; right_collide_v = '0;
    ts_collide = 1'b0; bs_collide = 1'b0;

    // Reset and idle
    cyc(3);
    chk("rst_x", Char_X_Pos, 10'd320);
    chk("rst_y", Char_Y_Pos, 10'd380);
    chk("rst_xm", Char_X_Motion, 10'd0);
    chk("rst_scr", {8'd0, screen_idx}, 10'd0);
    Reset_n = 1'b1;
    cyc(10);
    chk("idle_x", Char_X_Pos, 10'd320);

    // Walk on the floor of screen 0
    bottom_collide_v = 4'b0001;
    key_right = 1'b1;
    frames(5);
    chk("walk_x", Char_X_Pos, 10'd330);
    right_collide_v = 4'b0001;
    frame();
    chk("wall_xm", Char_X_Motion, 10'd0);
    chk("wall_x", Char_X_Pos, 10'd330);
    right_collide_v = '0;
    key_right = 1'b0;

    // Jump and gravity
    key_jump = 1'b1;
    frame();
    key_jump = 1'b0;
    chk("jump_ym", Char_Y_Motion, t10(-8));
    chk("jump_y", Char_Y_Pos, 10'd372);
    chk("jump_air", {9'd0, airborne}, 10'd1);
    bottom_collide_v = '0;
    for (int i = 0; i < 4; i++) begin
      frame();
      chk("grav_seq", Char_Y_Motion, t10(jump_seq[i]));
    end
    frames(30);
    chk("fall_cap", Char_Y_Motion, 10'd6);

    // Land, then ceiling bump at Y_Motion = -5
    bottom_collide_v = 4'b0001;
    frame();
    chk("land_air", {9'd0, airborne}, 10'd0);
    key_jump = 1'b1;
    frame();
    key_jump = 1'b0;
    bottom_collide_v = '0;
    frames(6);
    chk("rise_ym", Char_Y_Motion, t10(-5));
    top_collide_v = 4'b0001;
    frame();
    chk("ceil_ym", Char_Y_Motion, 10'd0);
    top_collide_v = '0;
    frames(2);
    chk("ceil_grav", Char_Y_Motion, 10'd1);

    // Screen up from 0, then back down
    bottom_collide_v = 4'b0001;
    frames(2);
    key_jump = 1'b1;
    frame();
    key_jump = 1'b0;
    bottom_collide_v = '0;
    ts_collide = 1'b1;
    frame();
    ts_collide = 1'b0;
    chk("up_scr", {8'd0, screen_idx}, 10'd1);
    chk("up_y", Char_Y_Pos, 10'd440);
    bs_collide = 1'b1;
    frame();
    bs_collide = 1'b0;
    chk("dn_scr", {8'd0, screen_idx}, 10'd0);
    chk("dn_y", Char_Y_Pos, 10'd40);

    // Climb to the last screen, then ts there must not transition
    for (int k = 0; k < 4; k++) begin
      bottom_collide_v = 4'b1111;
      frames(20);
      key_jump = 1'b1;
      frame();
      key_jump = 1'b0;
      bottom_collide_v = '0;
      ts_collide = 1'b1;
      frame();
      ts_collide = 1'b0;
    end
    chk("last_scr", {8'd0, screen_idx}, 10'd3);

    // Second tick during SAMPLE gives exactly one update
    bottom_collide_v = 4'b1111;
    frames(20);
    key_right = 1'b1;
    frame_tick = 1'b1;
    cyc(2);
    frame_tick = 1'b0;
    cyc(5);
    key_right = 1'b0;
    chk("dbl_tick_x", Char_X_Pos, 10'd332);

    // Randomized frames
    for (int f = 0; f < 80; f++) begin
      key_left         = 1'($urandom_range(0, 1));
      key_right        = 1'($urandom_range(0, 1));
      key_jump         = 1'($urandom_range(0, 1));
      top_collide_v    = 4'($urandom_range(0, 15));
      bottom_collide_v = 4'($urandom_range(0, 15));
      left_collide_v   = 4'($urandom_range(0, 15));
      right_collide_v  = 4'($urandom_range(0, 15));
      ts_collide       = ($urandom_range(0, 3) == 0);
      bs_collide       = ($urandom_range(0, 3) == 0);
      ticklen          = $urandom_range(1, 3);
      gap              = $urandom_range(0, 3);
      frame_tick = 1'b1;
      cyc(ticklen);
      frame_tick = 1'b0;
      cyc(5 + gap);
    end
    key_left = 1'b0; key_right = 1'b0; key_jump = 1'b0;
    top_collide_v = '0; left_collide_v = '0; right_collide_v = '0;
    ts_collide = 1'b0; bs_collide = 1'b0;

    // Reset while the sequencer is in UPDATE
    bottom_collide_v = 4'b0001;
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    cyc(1);
    Reset_n = 1'b0;
    #1;
    cmp_all();
    chk("mid_rst_x", Char_X_Pos, 10'd320);
    chk("mid_rst_y", Char_Y_Pos, 10'd380);
    chk("mid_rst_ym", Char_Y_Motion, 10'd0);
    chk("mid_rst_scr", {8'd0, screen_idx}, 10'd0);
    cyc(2);
    Reset_n = 1'b1;
    cyc(3);
    key_right = 1'b1;
    frame();
    key_right = 1'b0;
    chk("post_rst_x", Char_X_Pos, 10'd322);
    chk("post_rst_y", Char_Y_Pos, 10'd380);
    cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
